// File: rtl/io_pkg.sv
// io_pkg: shared defaults and types for the multi-channel I/O port block.
//
// Contents:
//   DATA_W_DEF    default port / data-bus width
//   CHANNELS_DEF  default number of input and output channels
//   DEPTH_DEF     default per-channel input FIFO depth
//   io_cmd_t      MEM-stage I/O command classification
package io_pkg;

    localparam int unsigned DATA_W_DEF   = 16;
    localparam int unsigned CHANNELS_DEF = 2;
    localparam int unsigned DEPTH_DEF    = 4;

    typedef enum logic [1:0] {
        IO_NOP = 2'd0,
        IO_IN  = 2'd1,
        IO_OUT = 2'd2
    } io_cmd_t;

    // Width of a channel index; never narrower than one bit.
    function automatic int unsigned sel_width(input int unsigned channels);
        return (channels > 1) ? $clog2(channels) : 1;
    endfunction

endpackage

// File: rtl/io_in_fifo.sv
// io_in_fifo: one input channel FIFO of the I/O port block.
//
// Pointers carry an extra wrap bit: empty when both pointers are equal, full when the
// index bits match and the wrap bits differ. Pushes while full and pops while empty are
// dropped. Reset (synchronous, active low) empties the FIFO and blocks the memory write.
//
// Ports:
//   clk_i    clock, rising edge
//   rst_ni   synchronous active-low reset
//   push_i   write wdata_i at the tail
//   pop_i    advance the head
//   wdata_i  data to push
//   full_o   FIFO holds DEPTH words
//   empty_o  FIFO holds no words
//   head_o   oldest word (valid only while !empty_o)
module io_in_fifo #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned DEPTH  = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic              full_o,
    output logic              empty_o,
    output logic [DATA_W-1:0] head_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);

    logic [PtrW:0]       wr_ptr_q, wr_ptr_d;
    logic [PtrW:0]       rd_ptr_q, rd_ptr_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];
    logic                do_push;
    logic                do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]) &&
                     (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]);
    assign head_o  = mem_q[rd_ptr_q[PtrW-1:0]];

    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset; the pointers define what is valid.
    always_ff @(posedge clk_i) begin
        if (rst_ni && do_push) begin
            mem_q[wr_ptr_q[PtrW-1:0]] <= wdata_i;
        end
    end

endmodule

// File: rtl/io_port_unit.sv
// io_port_unit: multi-channel I/O port block serving IN/OUT instructions from the MEM stage.
//
// Each input channel is buffered by an io_in_fifo (valid/ready on the external side). An IN
// to an empty channel asserts io_stall until the FIFO holds data; there is no empty-FIFO
// bypass, so a freshly pushed word is poppable from the following cycle. io_rdata is
// registered and holds until the next pop. Each output channel has a holding register and
// a one-cycle strobe. An out-of-range io_sel ignores OUT and makes IN return zero.
//
// Optional feature (macro IO_IRQ_EN): adds irq_mask/irq; irq is the registered OR of
// masked non-empty input channels. Without the macro neither port nor logic exists.
//
// Ports:
//   clk             processor clock, rising edge
//   reset           synchronous active-low reset
//   io_out_we       OUT instruction in MEM
//   io_in_re        IN instruction in MEM
//   io_sel          channel index for IN/OUT
//   io_wdata        OUT data
//   io_rdata        IN data, registered
//   io_stall        freeze pipeline (combinational)
//   port_in         external input data, ch k = [k*DATA_W +: DATA_W]
//   port_in_valid   external input valid per channel
//   port_in_ready   FIFO can accept, per channel
//   port_out        output holding registers
//   port_out_valid  one-cycle write strobe per channel
//   irq_mask        (IO_IRQ_EN) per-channel interrupt enable
//   irq             (IO_IRQ_EN) registered interrupt
module io_port_unit
    import io_pkg::*;
#(
    parameter  int unsigned DATA_W   = DATA_W_DEF,
    parameter  int unsigned CHANNELS = CHANNELS_DEF,
    parameter  int unsigned DEPTH    = DEPTH_DEF,
    localparam int unsigned SEL_W    = sel_width(CHANNELS)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       io_out_we,
    input  logic                       io_in_re,
    input  logic [SEL_W-1:0]           io_sel,
    input  logic [DATA_W-1:0]          io_wdata,
    output logic [DATA_W-1:0]          io_rdata,
    output logic                       io_stall,
`ifdef IO_IRQ_EN
    input  logic [CHANNELS-1:0]        irq_mask,
    output logic                       irq,
`endif
    input  logic [CHANNELS*DATA_W-1:0] port_in,
    input  logic [CHANNELS-1:0]        port_in_valid,
    output logic [CHANNELS-1:0]        port_in_ready,
    output logic [CHANNELS*DATA_W-1:0] port_out,
    output logic [CHANNELS-1:0]        port_out_valid
);

    // CHANNELS needs one more bit than an index when it is a power of two.
    localparam logic [SEL_W:0] ChanLim = (SEL_W + 1)'(CHANNELS);

    logic                       sel_ok;
    logic [CHANNELS-1:0]        sel_hit;
    logic [CHANNELS-1:0]        fifo_full;
    logic [CHANNELS-1:0]        fifo_empty;
    logic [CHANNELS-1:0]        fifo_push;
    logic [CHANNELS-1:0]        fifo_pop;
    logic [DATA_W-1:0]          fifo_head [CHANNELS];

    logic                       empty_sel;
    logic [DATA_W-1:0]          head_sel;
    logic                       pop_any;

    logic [DATA_W-1:0]          rdata_q, rdata_d;
    logic [CHANNELS*DATA_W-1:0] port_out_q, port_out_d;
    logic [CHANNELS-1:0]        out_valid_q, out_valid_d;

    assign sel_ok = ({1'b0, io_sel} < ChanLim);

    for (genvar k = 0; k < CHANNELS; k++) begin : g_chan
        assign sel_hit[k]       = sel_ok && (io_sel == SEL_W'(k));
        // Ready is a function of state only, so a same-cycle pop cannot raise it.
        assign port_in_ready[k] = reset & ~fifo_full[k];
        assign fifo_push[k]     = port_in_valid[k] & port_in_ready[k];
        assign fifo_pop[k]      = io_in_re & sel_hit[k];

        io_in_fifo #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH)
        ) u_in_fifo (
            .clk_i   (clk),
            .rst_ni  (reset),
            .push_i  (fifo_push[k]),
            .pop_i   (fifo_pop[k]),
            .wdata_i (port_in[k*DATA_W +: DATA_W]),
            .full_o  (fifo_full[k]),
            .empty_o (fifo_empty[k]),
            .head_o  (fifo_head[k])
        );
    end

    always_comb begin
        empty_sel = 1'b0;
        head_sel  = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (sel_hit[k]) begin
                empty_sel = fifo_empty[k];
                head_sel  = fifo_head[k];
            end
        end
    end

    assign io_stall = io_in_re & sel_ok & empty_sel;
    assign pop_any  = io_in_re & sel_ok & ~empty_sel;

    always_comb begin
        rdata_d = rdata_q;
        if (pop_any) begin
            rdata_d = head_sel;
        end else if (io_in_re && !sel_ok) begin
            rdata_d = '0;
        end
    end

    always_comb begin
        port_out_d  = port_out_q;
        out_valid_d = {CHANNELS{io_out_we}} & sel_hit;
        for (int k = 0; k < CHANNELS; k++) begin
            if (io_out_we && sel_hit[k]) begin
                port_out_d[k*DATA_W +: DATA_W] = io_wdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rdata_q     <= '0;
            port_out_q  <= '0;
            out_valid_q <= '0;
        end else begin
            rdata_q     <= rdata_d;
            port_out_q  <= port_out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign io_rdata       = rdata_q;
    assign port_out       = port_out_q;
    assign port_out_valid = out_valid_q;

`ifdef IO_IRQ_EN
    logic irq_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= |(~fifo_empty & irq_mask);
        end
    end

    assign irq = irq_q;
`endif

endmodule

// File: tb/tb_io_port_unit.sv
module tb_io_port_unit;

    localparam int DW    = 16;
    // Three channels give a two-bit selector, so io_sel=3 is a genuinely out-of-range index.
    localparam int CH    = 3;
    localparam int DEPTH = 4;
    localparam int SW    = 2;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              io_out_we = 1'b0;
    logic              io_in_re = 1'b0;
    logic [SW-1:0]     io_sel = '0;
    logic [DW-1:0]     io_wdata = '0;
    logic [DW-1:0]     io_rdata;
    logic              io_stall;
    logic [CH*DW-1:0]  port_in = '0;
    logic [CH-1:0]     port_in_valid = '0;
    logic [CH-1:0]     port_in_ready;
    logic [CH*DW-1:0]  port_out;
    logic [CH-1:0]     port_out_valid;
`ifdef IO_IRQ_EN
    logic [CH-1:0]     irq_mask = '0;
    logic              irq;
`endif

    int checks = 0;
    int failures = 0;

    io_port_unit #(
        .DATA_W   (DW),
        .CHANNELS (CH),
        .DEPTH    (DEPTH)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .io_out_we      (io_out_we),
        .io_in_re       (io_in_re),
        .io_sel         (io_sel),
        .io_wdata       (io_wdata),
        .io_rdata       (io_rdata),
        .io_stall       (io_stall),
`ifdef IO_IRQ_EN
        .irq_mask       (irq_mask),
        .irq            (irq),
`endif
        .port_in        (port_in),
        .port_in_valid  (port_in_valid),
        .port_in_ready  (port_in_ready),
        .port_out       (port_out),
        .port_out_valid (port_out_valid)
    );

    initial begin
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0h exp=%0h @%0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [DW-1:0]    mq [CH][$];
    logic [DW-1:0]    m_rdata = '0;
    logic [CH*DW-1:0] m_out = '0;
    logic [CH-1:0]    m_valid = '0;
    logic             m_irq = 1'b0;
    bit               started = 1'b0;
    int               pre_sz [CH];

    initial begin
        forever begin
            @(posedge clk);
            if (!reset) begin
                for (int k = 0; k < CH; k++) mq[k].delete();
                m_rdata = '0;
                m_out   = '0;
                m_valid = '0;
                m_irq   = 1'b0;
            end else begin
                for (int k = 0; k < CH; k++) pre_sz[k] = mq[k].size();
`ifdef IO_IRQ_EN
                m_irq = 1'b0;
                for (int k = 0; k < CH; k++) if (pre_sz[k] != 0 && irq_mask[k]) m_irq = 1'b1;
`endif
                if (io_in_re) begin
                    if (io_sel < CH) begin
                        if (pre_sz[io_sel] > 0) m_rdata = mq[io_sel].pop_front();
                    end else begin
                        m_rdata = '0;
                    end
                end
                for (int k = 0; k < CH; k++) begin
                    if (port_in_valid[k] && pre_sz[k] < DEPTH) mq[k].push_back(port_in[k*DW +: DW]);
                end
                m_valid = '0;
                if (io_out_we && io_sel < CH) begin
                    m_out[io_sel*DW +: DW] = io_wdata;
                    m_valid[io_sel] = 1'b1;
                end
            end
            started = 1'b1;
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    logic [CH-1:0] e_ready;
    logic          e_stall;
    initial begin
        forever begin
            @(negedge clk);
            if (started) begin
                for (int k = 0; k < CH; k++) e_ready[k] = reset && (mq[k].size() < DEPTH);
                e_stall = 1'b0;
                if (io_in_re && io_sel < CH) e_stall = (mq[io_sel].size() == 0);
                check("m_rdata", 64'(io_rdata), 64'(m_rdata));
                check("m_port_out", 64'(port_out), 64'(m_out));
                check("m_out_valid", 64'(port_out_valid), 64'(m_valid));
                check("m_ready", 64'(port_in_ready), 64'(e_ready));
                check("m_stall", 64'(io_stall), 64'(e_stall));
`ifdef IO_IRQ_EN
                check("m_irq", 64'(irq), 64'(m_irq));
`endif
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_in(input int k, input logic [DW-1:0] d);
        port_in[k*DW +: DW] = d;
        port_in_valid = '0;
        port_in_valid[k] = 1'b1;
    endtask

    initial begin
        // Reset held for two cycles.
        cyc();
        cyc();
        check("rst_port_out", 64'(port_out), 64'h0);
        check("rst_rdata", 64'(io_rdata), 64'h0);
        check("rst_ready", 64'(port_in_ready), 64'h0);
        reset = 1'b1;
        #1;
        check("post_rst_ready", 64'(port_in_ready), 64'h7);
        check("post_rst_stall", 64'(io_stall), 64'h0);

        // Two pushes on ch0, then two pops.
        drive_in(0, 16'h0010);
        cyc();
        drive_in(0, 16'h0020);
        cyc();
        port_in_valid = '0;
        io_in_re = 1'b1;
        io_sel = 2'd0;
        #1;
        check("in0_nostall", 64'(io_stall), 64'h0);
        cyc();
        check("in0_first", 64'(io_rdata), 64'h0010);
        cyc();
        check("in0_second", 64'(io_rdata), 64'h0020);

        // IN on empty ch1 stalls until a push lands.
        io_sel = 2'd1;
        #1;
        check("in1_stall", 64'(io_stall), 64'h1);
        cyc();
        check("in1_rdata_hold", 64'(io_rdata), 64'h0020);
        drive_in(1, 16'h00AB);
        #1;
        check("in1_no_bypass", 64'(io_stall), 64'h1);
        cyc();
        port_in_valid = '0;
        #1;
        check("in1_stall_drop", 64'(io_stall), 64'h0);
        cyc();
        check("in1_data", 64'(io_rdata), 64'h00AB);
        io_in_re = 1'b0;

        // Fill ch0, reject a fifth word, then pop / pop+push / push / drain.
        for (int i = 0; i < 4; i++) begin
            drive_in(0, 16'h0100 + 16'(i));
            cyc();
        end
        drive_in(0, 16'h0104);
        #1;
        check("full_ready0", 64'(port_in_ready[0]), 64'h0);
        cyc();
        port_in_valid = '0;
        io_in_re = 1'b1;
        io_sel = 2'd0;
        cyc();
        check("pop_after_full", 64'(io_rdata), 64'h0100);
        check("ready0_after_pop", 64'(port_in_ready[0]), 64'h1);
        drive_in(0, 16'h0105);
        cyc();
        check("poppush_rdata", 64'(io_rdata), 64'h0101);
        check("poppush_ready0", 64'(port_in_ready[0]), 64'h1);
        io_in_re = 1'b0;
        drive_in(0, 16'h0106);
        cyc();
        port_in_valid = '0;
        #1;
        check("refull_ready0", 64'(port_in_ready[0]), 64'h0);
        io_in_re = 1'b1;
        cyc();
        check("drain0", 64'(io_rdata), 64'h0102);
        cyc();
        check("drain1", 64'(io_rdata), 64'h0103);
        cyc();
        check("drain2", 64'(io_rdata), 64'h0105);
        cyc();
        check("drain3", 64'(io_rdata), 64'h0106);
        check("drained_stall", 64'(io_stall), 64'h1);
        io_in_re = 1'b0;

        // OUT to ch1, then an out-of-range OUT and IN.
        io_out_we = 1'b1;
        io_sel = 2'd1;
        io_wdata = 16'hBEEF;
        cyc();
        check("out1_data", 64'(port_out), 64'h0000_BEEF_0000);
        check("out1_valid", 64'(port_out_valid), 64'h2);
        io_out_we = 1'b0;
        cyc();
        check("out1_strobe_end", 64'(port_out_valid), 64'h0);
        io_out_we = 1'b1;
        io_sel = 2'd3;
        io_wdata = 16'hDEAD;
        cyc();
        check("out3_ignored", 64'(port_out), 64'h0000_BEEF_0000);
        check("out3_novalid", 64'(port_out_valid), 64'h0);
        io_out_we = 1'b0;
        io_in_re = 1'b1;
        #1;
        check("in3_nostall", 64'(io_stall), 64'h0);
        cyc();
        check("in3_zero", 64'(io_rdata), 64'h0);
        io_in_re = 1'b0;

        // Simultaneous IN and OUT on ch2.
        drive_in(2, 16'h0055);
        cyc();
        port_in_valid = '0;
        io_in_re = 1'b1;
        io_out_we = 1'b1;
        io_sel = 2'd2;
        io_wdata = 16'h0077;
        cyc();
        check("inout_rdata", 64'(io_rdata), 64'h0055);
        check("inout_out", 64'(port_out), 64'h0077_BEEF_0000);
        check("inout_valid", 64'(port_out_valid), 64'h4);
        io_in_re = 1'b0;
        io_out_we = 1'b0;

        // Reset mid-operation discards buffered data.
        drive_in(0, 16'h0999);
        cyc();
        port_in_valid = '0;
        reset = 1'b0;
        cyc();
        check("midrst_out", 64'(port_out), 64'h0);
        check("midrst_rdata", 64'(io_rdata), 64'h0);
        check("midrst_ready", 64'(port_in_ready), 64'h0);
        reset = 1'b1;
        io_in_re = 1'b1;
        io_sel = 2'd0;
        #1;
        check("midrst_discard", 64'(io_stall), 64'h1);
        io_in_re = 1'b0;
        cyc();

`ifdef IO_IRQ_EN
        irq_mask = 3'b010;
        drive_in(1, 16'h00C1);
        cyc();
        port_in_valid = '0;
        check("irq_lag", 64'(irq), 64'h0);
        cyc();
        check("irq_rise", 64'(irq), 64'h1);
        io_in_re = 1'b1;
        io_sel = 2'd1;
        cyc();
        check("irq_pop_data", 64'(io_rdata), 64'h00C1);
        io_in_re = 1'b0;
        cyc();
        check("irq_fall", 64'(irq), 64'h0);
`endif

        cyc();
        cyc();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
